// File: rtl/int_decl_gen.sv
// Serializes a C-style integer declaration ("int a,b_1;") from a buffer of identifier characters.
// Optional macro KEYWORD_REJECT_EN rejects an identifier that completes as exactly "int".
module int_decl_gen #(
  parameter  int DEPTH   = 32,
  parameter  int MAX_IDS = 8,
  localparam int AW      = $clog2(DEPTH),
  localparam int IW      = $clog2(MAX_IDS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [7:0]    wr_char,
  input  logic          wr_last,
  input  logic          start,
  input  logic          out_ready,
  output logic [7:0]    out,
  output logic          out_valid,
  output logic          busy,
  output logic          full,
  output logic [IW-1:0] ids,
  output logic          err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KW_I,
    S_KW_N,
    S_KW_T,
    S_SP,
    S_ID,
    S_SEP
  } state_e;

  state_e          state_q, state_d;
  logic [8:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [IW-1:0]   ids_q, ids_d;
  logic [IW-1:0]   emit_left_q, emit_left_d;
  logic            open_q, open_d;
  logic            err_q, err_d;

  logic            idle;
  logic            full_w;
  logic            is_digit;
  logic            char_ok;
  logic            wr_ok;
  logic            start_ok;
  logic            store;
  logic            kw_reject;
  logic            xfer;
  logic [8:0]      rd_entry;

  assign idle     = (state_q == S_IDLE);
  assign full_w   = (count_q == (AW+1)'(DEPTH));
  assign is_digit = (wr_char >= "0") && (wr_char <= "9");
  assign char_ok  = is_digit
                 || ((wr_char >= "A") && (wr_char <= "Z"))
                 || ((wr_char >= "a") && (wr_char <= "z"))
                 || (wr_char == "_");
  assign wr_ok    = wr_en && idle && !full_w && char_ok
                 && !(!open_q && is_digit)
                 && !(wr_last && (ids_q >= IW'(MAX_IDS)));
  assign start_ok = start && idle && (ids_q != '0) && !open_q;
  // A start accepted in the same cycle wins; the concurrent write is discarded.
  assign store    = wr_ok && !start_ok && !kw_reject;
  assign rd_entry = mem_q[rd_ptr_q];
  assign xfer     = out_valid && out_ready;

`ifdef KEYWORD_REJECT_EN
  logic [AW-1:0] id_start_q, id_start_d;
  logic [1:0]    kw_len_q, kw_len_d;
  logic          kw_match_q, kw_match_d;

  // The first two characters of the open identifier are already stored as "in".
  assign kw_reject = wr_last && open_q && (kw_len_q == 2'd2) && kw_match_q
                  && (wr_char == "t");
`else
  assign kw_reject = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start_ok) state_d = S_KW_I;
      S_KW_I: if (xfer) state_d = S_KW_N;
      S_KW_N: if (xfer) state_d = S_KW_T;
      S_KW_T: if (xfer) state_d = S_SP;
      S_SP:   if (xfer) state_d = S_ID;
      S_ID:   if (xfer && rd_entry[8]) state_d = S_SEP;
      S_SEP:  if (xfer) state_d = (emit_left_q == '0) ? S_IDLE : S_ID;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    out       = 8'h00;
    out_valid = 1'b1;
    unique case (state_q)
      S_IDLE: out_valid = 1'b0;
      S_KW_I: out = "i";
      S_KW_N: out = "n";
      S_KW_T: out = "t";
      S_SP:   out = " ";
      S_ID:   out = rd_entry[7:0];
      S_SEP:  out = (emit_left_q == '0) ? ";" : ",";
      default: out_valid = 1'b0;
    endcase
  end

  assign busy = !idle;
  assign full = full_w;
  assign ids  = ids_q;
  assign err  = err_q;

  // Buffer and bookkeeping next-state
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    ids_d       = ids_q;
    emit_left_d = emit_left_q;
    open_d      = open_q;
    err_d       = err_q;
`ifdef KEYWORD_REJECT_EN
    id_start_d  = id_start_q;
    kw_len_d    = kw_len_q;
    kw_match_d  = kw_match_q;
`endif

    if (start_ok) begin
      err_d       = 1'b0;
      emit_left_d = ids_q;
    end

    if (store) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      count_d  = count_q + (AW+1)'(1);
      open_d   = !wr_last;
      if (wr_last) ids_d = ids_q + IW'(1);
`ifdef KEYWORD_REJECT_EN
      if (!open_q) begin
        id_start_d = wr_ptr_q;
        kw_len_d   = 2'd1;
        kw_match_d = (wr_char == "i");
      end else begin
        if (kw_len_q != 2'd3) kw_len_d = kw_len_q + 2'd1;
        kw_match_d = kw_match_q && (kw_len_q == 2'd1) && (wr_char == "n");
      end
`endif
    end

`ifdef KEYWORD_REJECT_EN
    if (wr_ok && !start_ok && kw_reject) begin
      wr_ptr_d = id_start_q;
      count_d  = count_q - {{(AW-1){1'b0}}, kw_len_q};
      open_d   = 1'b0;
    end
`endif

    if ((wr_en && !store) || (start && !start_ok)) err_d = 1'b1;

    if (state_q == S_ID && xfer) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      if (rd_entry[8]) emit_left_d = emit_left_q - IW'(1);
    end

    // The ';' transfer retires the whole declaration and empties the buffer.
    if (state_q == S_SEP && xfer && emit_left_q == '0) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ids_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ids_q       <= '0;
      emit_left_q <= '0;
      open_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ids_q       <= ids_d;
      emit_left_q <= emit_left_d;
      open_q      <= open_d;
      err_q       <= err_d;
    end
  end

`ifdef KEYWORD_REJECT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_start_q <= '0;
      kw_len_q   <= '0;
      kw_match_q <= 1'b0;
    end else begin
      id_start_q <= id_start_d;
      kw_len_q   <= kw_len_d;
      kw_match_q <= kw_match_d;
    end
  end
`endif

  // NOTE: the storage array has no reset; entries are only read between pointers that reset does clear.
  always_ff @(posedge clk) begin
    if (store) mem_q[wr_ptr_q] <= {wr_last, wr_char};
  end

endmodule

// File: doc/int_decl_gen.md
Name: int_decl_gen

Overview:
Character-stream transmitter for C-style integer declarations, the counterpart of the declaration checker that consumes one ASCII byte per clock. Identifier characters are loaded into an internal buffer. On start, the block serializes a complete declaration, e.g. "int a,b_1;", one byte per accepted handshake. It is intended to drive the checker's 8-bit char input in self-checking loopback benches and in on-chip stimulus generation.

Parameters:
DEPTH, 32, identifier-character buffer entries; power of 2, minimum 4
MAX_IDS, 8, maximum identifiers per declaration; ids counter width = clog2(MAX_IDS+1)

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset
wr_en  input  1  write one identifier character into buffer
wr_char  input  8  ASCII character to write
wr_last  input  1  with wr_en: this char ends the current identifier
start  input  1  single-cycle pulse: begin emitting declaration
out_ready  input  1  consumer accepts out this cycle
out  output  8  ASCII byte being presented
out_valid  output  1  out holds a valid byte
busy  output  1  emission in progress
full  output  1  buffer holds DEPTH entries
ids  output  clog2(MAX_IDS+1)  completed identifiers in buffer
err  output  1  sticky error flag

Behaviour:
- Reset (reset=0, async): out=8'h00, out_valid=0, busy=0, full=0, ids=0, err=0, buffer empty, state IDLE. Reset asserted mid-stream aborts the stream immediately; no partial byte survives.
- Buffer entry = {last bit, char}. Write pointer and read pointer run modulo DEPTH. full = (entry count == DEPTH).
- Write acceptance requires state IDLE and !full. The char must be in [A-Za-z0-9_] and must not be a digit when it is the first char of an identifier. With wr_last=1, ids must also be < MAX_IDS. A write failing any rule is dropped and sets err=1.
- Accepted write: entry stored next cycle. wr_last=1 increments ids and closes the identifier ("open" flag cleared).
- start is accepted only in IDLE with ids>=1 and no open identifier. Otherwise start is ignored and sets err=1. start and wr_en in the same cycle: start is evaluated on pre-write state; if start is accepted, the write is dropped and err=1.
- Accepted start clears err and enters KW_I. busy=1 from the next cycle.
- FSM: IDLE -> KW_I('i') -> KW_N('n') -> KW_T('t') -> SP(' ') -> ID(buffer chars) -> SEP -> ID or IDLE.
- SEP emits ',' if the identifier just sent was not the final one, else ';'. After the ';' transfer: buffer emptied, ids=0, busy=0, state IDLE.
- Each state presents its byte with out_valid=1 and holds out stable until out_valid&&out_ready at a clock edge. The next byte appears the following cycle, giving full throughput of 1 byte/clk while out_ready=1.
- out_valid never deasserts without a transfer, except on reset. out=8'h00 whenever out_valid=0.
- Latency: first byte 'i' valid 1 cycle after the start edge. Total bytes = 4 + total chars + ids.
- Writes during busy are dropped with err=1. start during busy is ignored with err=1.

Optional Feature:
KEYWORD_REJECT_EN: when defined, an identifier that completes as exactly "int" (3 chars) is rejected at its wr_last write. The write pointer rolls back to the identifier's first entry, ids is unchanged, open is cleared, and err=1. When undefined, "int" is accepted as an ordinary identifier.

Test Plan:
- Write a(last), b,_,1(last); start; out_ready=1 -> out = "int a,b_1;" on 10 consecutive cycles, then busy=0, ids=0, full=0.
- Same load with out_ready toggling 1/0 each cycle -> identical byte sequence, each byte held stable while stalled, no drops or repeats.
- Write '1' as first char, then ';' -> both dropped, err=1, ids=0. Start then emits only later legal content and clears err.
- start with ids=0, then start after x without wr_last -> out_valid stays 0, err=1.
- Write DEPTH=32 chars, then one more -> full=1, 33rd dropped, err=1. Emission outputs all 32 chars in order.
- Pull reset low after "in" has been emitted -> out_valid=0 and busy=0 immediately, ids=0. With KEYWORD_REJECT_EN, a later write of i,n,t(last) -> err=1, ids=0.
